// File: rtl/host_mem_loader.sv
// Byte-stream host loader: parses write/run command packets into processor memory writes.
// Optional trailing checksum byte per write packet when LOADER_CHECKSUM_EN is defined.
module host_mem_loader #(
  parameter int unsigned WIDTH_INST_MEM   = 80,
  parameter int unsigned WIDTH_PARAM_MEM  = 128,
  parameter int unsigned WIDTH_ACT_MEM    = 8,
  parameter int unsigned WIDTH_ADDR_INST  = 6,
  parameter int unsigned WIDTH_ADDR_PARAM = 13,
  parameter int unsigned WIDTH_ADDR_ACT   = 12
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [7:0]                  s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic                        sel_ext,
  output logic                        en,
  input  logic                        done,
  output logic                        wea_instmem_ext,
  output logic                        wea_parammem_ext,
  output logic                        wea_actmem_ext,
  output logic [WIDTH_INST_MEM-1:0]   instmem_in_ext,
  output logic [WIDTH_PARAM_MEM-1:0]  parammem_in_ext,
  output logic [WIDTH_ACT_MEM-1:0]    actmem_in_ext,
  output logic [WIDTH_ADDR_INST-1:0]  addr_instmem_ext,
  output logic [WIDTH_ADDR_PARAM-1:0] addr_parammem_ext,
  output logic [WIDTH_ADDR_ACT-1:0]   addr_actmem_ext,
  output logic                        busy,
  output logic                        run_done,
  output logic                        err_opcode,
  output logic                        err_csum
);

  localparam int unsigned W_IP  = (WIDTH_INST_MEM > WIDTH_PARAM_MEM) ? WIDTH_INST_MEM : WIDTH_PARAM_MEM;
  localparam int unsigned MAXW  = (W_IP > WIDTH_ACT_MEM) ? W_IP : WIDTH_ACT_MEM;
  localparam int unsigned A_IP  = (WIDTH_ADDR_INST > WIDTH_ADDR_PARAM) ? WIDTH_ADDR_INST : WIDTH_ADDR_PARAM;
  localparam int unsigned AW    = (A_IP > WIDTH_ADDR_ACT) ? A_IP : WIDTH_ADDR_ACT;

  localparam logic [7:0] OP_INST  = 8'h01;
  localparam logic [7:0] OP_PARAM = 8'h02;
  localparam logic [7:0] OP_ACT   = 8'h03;
  localparam logic [7:0] OP_RUN   = 8'h10;

  localparam logic [7:0] INST_LAST  = 8'(WIDTH_INST_MEM / 8 - 1);
  localparam logic [7:0] PARAM_LAST = 8'(WIDTH_PARAM_MEM / 8 - 1);
  localparam logic [7:0] ACT_LAST   = 8'(WIDTH_ACT_MEM / 8 - 1);

  typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, WRITE, CHK, RUN} state_t;
  typedef enum logic [1:0] {T_INST, T_PARAM, T_ACT} target_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_END = CHK;
`else
  localparam state_t S_END = IDLE;
`endif

  state_t          state, state_next;
  target_t         target;
  logic [1:0]      hdr_idx;
  logic [7:0]      addr_lo, cnt_lo;
  logic [AW-1:0]   addr;
  logic [15:0]     cnt;
  logic [7:0]      byte_idx, last_idx;
  logic [MAXW-9:0] word_buf;
  logic [MAXW-1:0] word_shift;
  logic            first_run;
  logic            xfer;

  assign xfer = s_valid & s_ready;
  // Bytes arrive LSB first, so shifting in from the top leaves the word in the upper W bits.
  assign word_shift = {s_data, word_buf};

  always_comb begin
    last_idx = ACT_LAST;
    case (target)
      T_INST:  last_idx = INST_LAST;
      T_PARAM: last_idx = PARAM_LAST;
      default: last_idx = ACT_LAST;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next       = state;
    s_ready          = 1'b0;
    sel_ext          = 1'b0;
    en               = 1'b0;
    busy             = (state != IDLE);
    wea_instmem_ext  = 1'b0;
    wea_parammem_ext = 1'b0;
    wea_actmem_ext   = 1'b0;
    case (state)
      IDLE: begin
        s_ready = 1'b1;
        if (xfer) begin
          case (s_data)
            OP_INST, OP_PARAM, OP_ACT: state_next = HDR;
            OP_RUN:                    state_next = RUN;
            default:                   state_next = IDLE;
          endcase
        end
      end
      HDR: begin
        s_ready = 1'b1;
        sel_ext = 1'b1;
        if (xfer && hdr_idx == 2'd3)
          state_next = ({s_data, cnt_lo} == 16'd0) ? S_END : PAYLOAD;
      end
      PAYLOAD: begin
        s_ready = 1'b1;
        sel_ext = 1'b1;
        if (xfer && byte_idx == last_idx) state_next = WRITE;
      end
      WRITE: begin
        sel_ext          = 1'b1;
        wea_instmem_ext  = (target == T_INST);
        wea_parammem_ext = (target == T_PARAM);
        wea_actmem_ext   = (target == T_ACT);
        state_next       = (cnt == 16'd1) ? S_END : PAYLOAD;
      end
      CHK: begin
        s_ready = 1'b1;
        sel_ext = 1'b1;
        if (xfer) state_next = IDLE;
      end
      RUN: begin
        en = 1'b1;
        if (done && !first_run) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      target            <= T_INST;
      hdr_idx           <= '0;
      addr_lo           <= '0;
      cnt_lo            <= '0;
      addr              <= '0;
      cnt               <= '0;
      byte_idx          <= '0;
      word_buf          <= '0;
      first_run         <= 1'b1;
      run_done          <= 1'b0;
      err_opcode        <= 1'b0;
      instmem_in_ext    <= '0;
      parammem_in_ext   <= '0;
      actmem_in_ext     <= '0;
      addr_instmem_ext  <= '0;
      addr_parammem_ext <= '0;
      addr_actmem_ext   <= '0;
    end else begin
      first_run <= (state != RUN);
      run_done  <= (state == RUN) && done && !first_run;
      case (state)
        IDLE: begin
          hdr_idx  <= '0;
          byte_idx <= '0;
          if (xfer) begin
            case (s_data)
              OP_INST:  target <= T_INST;
              OP_PARAM: target <= T_PARAM;
              OP_ACT:   target <= T_ACT;
              OP_RUN:   ;
              default:  err_opcode <= 1'b1;
            endcase
          end
        end
        HDR: begin
          if (xfer) begin
            hdr_idx <= hdr_idx + 2'd1;
            case (hdr_idx)
              2'd0: addr_lo <= s_data;
              2'd1: addr    <= AW'({s_data, addr_lo});
              2'd2: cnt_lo  <= s_data;
              default: cnt  <= {s_data, cnt_lo};
            endcase
          end
        end
        PAYLOAD: begin
          if (xfer) begin
            word_buf <= word_shift[MAXW-1:8];
            if (byte_idx == last_idx) begin
              byte_idx <= '0;
              case (target)
                T_INST: begin
                  instmem_in_ext   <= word_shift[MAXW-1 -: WIDTH_INST_MEM];
                  addr_instmem_ext <= addr[WIDTH_ADDR_INST-1:0];
                end
                T_PARAM: begin
                  parammem_in_ext   <= word_shift[MAXW-1 -: WIDTH_PARAM_MEM];
                  addr_parammem_ext <= addr[WIDTH_ADDR_PARAM-1:0];
                end
                default: begin
                  actmem_in_ext   <= word_shift[MAXW-1 -: WIDTH_ACT_MEM];
                  addr_actmem_ext <= addr[WIDTH_ADDR_ACT-1:0];
                end
              endcase
            end else begin
              byte_idx <= byte_idx + 8'd1;
            end
          end
        end
        WRITE: begin
          addr <= addr + AW'(1);
          cnt  <= cnt - 16'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      csum     <= '0;
      err_csum <= 1'b0;
    end else if (xfer) begin
      case (state)
        IDLE:         csum <= s_data;
        HDR, PAYLOAD: csum <= csum + s_data;
        CHK:          if (s_data != csum) err_csum <= 1'b1;
        default:      ;
      endcase
    end
  end
`else
  assign err_csum = 1'b0;
`endif

endmodule
